// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi decoder front end: FSM state
// encoding, the branch-metric field width, the reference symbol pairs and how o_bm is packed.
package viterbi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } bmu_state_t;

    localparam int SIZE_BM = 2;

    localparam logic [1:0] PAIR_00 = 2'b00;
    localparam logic [1:0] PAIR_01 = 2'b01;
    localparam logic [1:0] PAIR_10 = 2'b10;
    localparam logic [1:0] PAIR_11 = 2'b11;

    // Hamming weight of a 2-bit value: {both set, exactly one set}.
    function automatic logic [SIZE_BM-1:0] popcount2(input logic [1:0] x);
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    // The ACS stage expects bm3 in the top bits and bm0 in the bottom bits.
    function automatic logic [4*SIZE_BM-1:0] pack_bm(
        input logic [SIZE_BM-1:0] bm0,
        input logic [SIZE_BM-1:0] bm1,
        input logic [SIZE_BM-1:0] bm2,
        input logic [SIZE_BM-1:0] bm3
    );
        return {bm3, bm2, bm1, bm0};
    endfunction

endpackage

// File: rtl/bmu_hamming2.sv
// Combinational Hamming branch metrics for one rate-1/2 symbol pair against
// the four possible encoder output pairs.
module bmu_hamming2
    import viterbi_pkg::*;
(
    input  logic [1:0]           pair_i,
    output logic [4*SIZE_BM-1:0] bm_o
);

    logic [SIZE_BM-1:0] bm0;
    logic [SIZE_BM-1:0] bm1;
    logic [SIZE_BM-1:0] bm2;
    logic [SIZE_BM-1:0] bm3;

    assign bm0  = popcount2(pair_i ^ PAIR_00);
    assign bm1  = popcount2(pair_i ^ PAIR_01);
    assign bm2  = popcount2(pair_i ^ PAIR_10);
    assign bm3  = popcount2(pair_i ^ PAIR_11);
    assign bm_o = pack_bm(bm0, bm1, bm2, bm3);

endmodule

// File: rtl/viterbi_bmu_reader.sv
// Pops packed hard-decision words from the symbol FIFO, unpacks them LSB pair
// first and streams per-pair Hamming branch metrics to the ACS stage.
module viterbi_bmu_reader
    import viterbi_pkg::*;
#(
    parameter int SIZE_DATA = 8,
    parameter int SIZE_LEN  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SIZE_LEN-1:0]  i_frame_len,
    input  logic                 i_fifo_empty,
    input  logic [SIZE_DATA-1:0] i_fifo_data,
    output logic                 o_fifo_rd_en,
    output logic                 o_bm_valid,
    input  logic                 i_bm_ready,
    output logic [7:0]           o_bm,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int PAIRS = SIZE_DATA / 2;
    localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAIRS - 1);

    bmu_state_t           state_q;
    logic [SIZE_DATA-1:0] word_q;
    logic [IDX_W-1:0]     pair_idx_q;
    logic [SIZE_LEN-1:0]  remaining_q;

    logic [1:0]           pair_cur;
    logic [7:0]           bm_cur;
    logic                 xfer;
    logic                 last_pair;

    assign pair_cur  = word_q[{pair_idx_q, 1'b0} +: 2];
    assign last_pair = (remaining_q == SIZE_LEN'(1));

    bmu_hamming2 u_hamming (
        .pair_i (pair_cur),
        .bm_o   (bm_cur)
    );

    // Everything below except the FIFO read strobe is decoded from registers only.
    assign o_bm_valid   = (state_q == ST_EMIT);
    assign o_bm         = o_bm_valid ? bm_cur : 8'h00;
    assign o_last       = o_bm_valid & last_pair;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = (state_q == ST_DONE);
    assign o_fifo_rd_en = (state_q == ST_FETCH) & ~i_fifo_empty;
    assign xfer         = o_bm_valid & i_bm_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            pair_idx_q  <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        remaining_q <= i_frame_len;
                        state_q     <= (i_frame_len == '0) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (!i_fifo_empty) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    word_q     <= i_fifo_data;
                    pair_idx_q <= '0;
                    state_q    <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (xfer) begin
                        pair_idx_q <= pair_idx_q + IDX_W'(1);
                        if (remaining_q != '0) begin
                            remaining_q <= remaining_q - SIZE_LEN'(1);
                        end
                        // A short final word simply drops its unused pairs.
                        if (last_pair) begin
                            state_q <= ST_DONE;
                        end else if (pair_idx_q == LAST_IDX) begin
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_bmu_reader.sv
// Directed bench for viterbi_bmu_reader with a small behavioural FIFO in front.
module tb_viterbi_bmu_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [15:0] frame_len;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       bm_valid;
    logic       bm_ready;
    logic [7:0] bm;
    logic       last;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    int rd_count = 0;
    int fifo_cnt = 0;
    logic [7:0] fifo_mem[$];

    viterbi_bmu_reader #(.SIZE_DATA(8), .SIZE_LEN(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_frame_len  (frame_len),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_rd_en (fifo_rd_en),
        .o_bm_valid   (bm_valid),
        .i_bm_ready   (bm_ready),
        .o_bm         (bm),
        .o_last       (last),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty = (fifo_cnt == 0);

    always @(posedge clk) begin
        if (fifo_rd_en && fifo_cnt > 0) begin
            fifo_data <= fifo_mem.pop_front();
            fifo_cnt  <= fifo_cnt - 1;
            rd_count  <= rd_count + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        fifo_mem.push_back(w);
        fifo_cnt = fifo_cnt + 1;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] len);
        start     = 1'b1;
        frame_len = len;
        tick();
        start     = 1'b0;
        #1;
    endtask

    logic [7:0] exp_seq [6] = '{8'h94, 8'h61, 8'h49, 8'h16, 8'h94, 8'h61};
    int n;
    int rd_before;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        frame_len = '0;
        bm_ready  = 1'b1;
        fifo_data = '0;
        #1;
        check_eq("rst_bm", {24'h0, bm}, 32'h0);
        check_eq("rst_outs", {27'h0, bm_valid, last, busy, done, fifo_rd_en}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset released");

        // Frame of 4 pairs from a single word E4, ready held high.
        push(8'hE4);
        start_frame(16'd4);
        check_eq("t1_rd_en_c1", {31'h0, fifo_rd_en}, 32'h1);
        check_eq("t1_busy_c1", {31'h0, busy}, 32'h1);
        tick(); #1;
        check_eq("t1_wait_valid", {31'h0, bm_valid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check_eq($sformatf("t1_valid%0d", i), {31'h0, bm_valid}, 32'h1);
            check_eq($sformatf("t1_bm%0d", i), {24'h0, bm}, {24'h0, exp_seq[i]});
            check_eq($sformatf("t1_last%0d", i), {31'h0, last}, (i == 3) ? 32'h1 : 32'h0);
            $display("t1 pair %0d bm=%02h last=%0b", i, bm, last);
        end
        tick(); #1;
        check_eq("t1_done", {31'h0, done}, 32'h1);
        check_eq("t1_done_valid", {31'h0, bm_valid}, 32'h0);
        tick(); #1;
        check_eq("t1_done_pulse", {31'h0, done}, 32'h0);
        check_eq("t1_idle", {31'h0, busy}, 32'h0);

        // Zero-length frame: straight to DONE, no read.
        rd_before = rd_count;
        start_frame(16'd0);
        check_eq("t2_done", {31'h0, done}, 32'h1);
        check_eq("t2_rd_en", {31'h0, fifo_rd_en}, 32'h0);
        check_eq("t2_valid", {31'h0, bm_valid}, 32'h0);
        tick(); #1;
        check_eq("t2_idle", {31'h0, busy}, 32'h0);
        check_eq("t2_reads", rd_count - rd_before, 32'd0);
        $display("t2 zero-length frame complete");

        // Six pairs across two words; tail of second word discarded.
        push(8'hE4);
        push(8'hE4);
        rd_before = rd_count;
        n = 0;
        start_frame(16'd6);
        for (int c = 0; c < 14 && busy; c++) begin
            if (bm_valid && bm_ready) begin
                if (n < 6) check_eq($sformatf("t3_bm%0d", n), {24'h0, bm}, {24'h0, exp_seq[n]});
                check_eq($sformatf("t3_last%0d", n), {31'h0, last}, (n == 5) ? 32'h1 : 32'h0);
                $display("t3 transfer %0d bm=%02h last=%0b", n, bm, last);
                n++;
            end
            tick(); #1;
        end
        check_eq("t3_count", n, 32'd6);
        check_eq("t3_reads", rd_count - rd_before, 32'd2);
        check_eq("t3_idle", {31'h0, busy}, 32'h0);

        // FIFO empty for 5 cycles after start.
        start_frame(16'd1);
        for (int c = 0; c < 5; c++) begin
            check_eq($sformatf("t4_hold_rd%0d", c), {31'h0, fifo_rd_en}, 32'h0);
            check_eq($sformatf("t4_hold_busy%0d", c), {31'h0, busy}, 32'h1);
            tick(); #1;
        end
        push(8'hE4);
        #1;
        check_eq("t4_rd_en", {31'h0, fifo_rd_en}, 32'h1);
        tick(); #1;
        check_eq("t4_wait", {31'h0, bm_valid}, 32'h0);
        tick(); #1;
        check_eq("t4_valid", {31'h0, bm_valid}, 32'h1);
        check_eq("t4_bm", {24'h0, bm}, 32'h94);
        check_eq("t4_last", {31'h0, last}, 32'h1);
        tick(); #1;
        check_eq("t4_done", {31'h0, done}, 32'h1);
        tick(); #1;
        $display("t4 empty-stall frame complete");

        // Backpressure on the first pair.
        push(8'hE4);
        bm_ready = 1'b0;
        start_frame(16'd2);
        tick(); #1;
        tick(); #1;
        for (int c = 0; c < 3; c++) begin
            check_eq($sformatf("t5_hold_bm%0d", c), {24'h0, bm}, 32'h94);
            check_eq($sformatf("t5_hold_valid%0d", c), {31'h0, bm_valid}, 32'h1);
            check_eq($sformatf("t5_hold_last%0d", c), {31'h0, last}, 32'h0);
            tick(); #1;
        end
        bm_ready = 1'b1;
        #1;
        check_eq("t5_bm0", {24'h0, bm}, 32'h94);
        tick(); #1;
        check_eq("t5_bm1", {24'h0, bm}, 32'h61);
        check_eq("t5_last1", {31'h0, last}, 32'h1);
        tick(); #1;
        check_eq("t5_done", {31'h0, done}, 32'h1);
        tick(); #1;
        $display("t5 backpressure frame complete");

        // Reset mid-EMIT, then a fresh frame from the next FIFO word.
        push(8'hE4);
        push(8'h1B);
        start_frame(16'd4);
        tick(); #1;
        tick(); #1;
        tick(); #1;
        check_eq("t6_pre_bm", {24'h0, bm}, 32'h61);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_bm", {24'h0, bm}, 32'h0);
        check_eq("t6_rst_outs", {27'h0, bm_valid, last, busy, done, fifo_rd_en}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        start_frame(16'd2);
        start     = 1'b1;
        frame_len = 16'd0;
        #1;
        check_eq("t6_rd_en", {31'h0, fifo_rd_en}, 32'h1);
        tick();
        start = 1'b0;
        #1;
        check_eq("t6_ignored_start", {31'h0, done}, 32'h0);
        tick(); #1;
        check_eq("t6_bm0", {24'h0, bm}, 32'h16);
        check_eq("t6_last0", {31'h0, last}, 32'h0);
        tick(); #1;
        check_eq("t6_bm1", {24'h0, bm}, 32'h49);
        check_eq("t6_last1", {31'h0, last}, 32'h1);
        tick(); #1;
        check_eq("t6_done", {31'h0, done}, 32'h1);
        tick(); #1;
        check_eq("t6_idle", {31'h0, busy}, 32'h0);
        $display("t6 reset-and-restart frame complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/viterbi_bmu_reader.md
# viterbi_bmu_reader

Downstream consumer of the encoded-symbol FIFO in the Viterbi decoder datapath. It pops packed hard-decision symbol words from the FIFO and unpacks them into rate-1/2 symbol pairs. For each pair it computes the four Hamming branch metrics and hands them to the add-compare-select stage over a valid/ready handshake, one pair per transfer, for a programmed frame length.

## Interface
- SIZE_DATA, 8: FIFO word width in bits; must be even and ≥2.
- SIZE_LEN, 16: width of the frame-length field, counted in symbol pairs.
- PAIRS (local), SIZE_DATA/2: symbol pairs per FIFO word.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  frame start pulse; sampled only in IDLE.
- i_frame_len  in  SIZE_LEN  frame length in pairs; latched when i_start is accepted.
- i_fifo_empty  in  1  FIFO empty flag.
- i_fifo_data  in  SIZE_DATA  FIFO read data; valid the cycle after an accepted read.
- o_fifo_rd_en  out  1  FIFO read enable.
- o_bm_valid  out  1  branch-metric word valid.
- i_bm_ready  in  1  ACS ready to accept.
- o_bm  out  8  packed metrics {bm3,bm2,bm1,bm0}, 2 bits each; bmk = popcount(pair ^ k).
- o_last  out  1  current pair is the last pair of the frame; qualified by o_bm_valid.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse at frame end.

## Operation
- States:
  - IDLE: waits for i_start.
  - FETCH: issues a FIFO read when the FIFO is not empty.
  - WAIT: one-cycle FIFO read latency; captures the word.
  - EMIT: presents one pair per transfer.
  - DONE: pulses o_done.
- IDLE → FETCH on i_start with i_frame_len != 0.
- IDLE → DONE on i_start with i_frame_len == 0. No FIFO read is issued.
- o_fifo_rd_en = (state==FETCH) & ~i_fifo_empty, combinational. At most one outstanding read.
- FETCH holds while the FIFO is empty. When a read is issued, FETCH → WAIT.
- WAIT: word_reg <= i_fifo_data; pair_idx <= 0; → EMIT.
- EMIT:
  - Current pair = word_reg[2*pair_idx+1 : 2*pair_idx], LSB pair first.
  - o_bm_valid = 1.
  - On valid & ready: pair_idx++ and remaining--.
  - If remaining was 1 → DONE.
  - Otherwise, if pair_idx was PAIRS-1 → FETCH.
  - Otherwise stay in EMIT.
- DONE: o_done = 1 for one cycle, then → IDLE.
- o_last = o_bm_valid & (remaining == 1).
- If the frame length is not a multiple of PAIRS, the unused pairs of the final word are discarded.
- i_start outside IDLE is ignored.
- While o_bm_valid & ~i_bm_ready, o_bm and o_last hold stable.
- Reset (async, any state):
  - state = IDLE; word_reg, pair_idx and remaining are cleared.
  - All outputs are 0, so o_bm = 8'h00.
  - Words already popped from the FIFO are lost. FIFO contents are not touched.

## Timing
- i_start accepted in cycle 0 with the FIFO non-empty:
  - rd_en in cycle 1.
  - WAIT in cycle 2.
  - First o_bm_valid in cycle 3.
- With i_bm_ready held high:
  - One pair per cycle within a word.
  - Two bubble cycles (FETCH, WAIT) between words, giving PAIRS per PAIRS+2 cycles.
- o_done asserts the cycle after the last handshake. o_busy drops the cycle after that.
- o_bm, o_last and o_bm_valid come from registered state only; there is no combinational path from i_bm_ready.
- o_fifo_rd_en depends combinationally on i_fifo_empty. This is safe because the FIFO computes empty from registered pointers.
- remaining is SIZE_LEN bits and never decrements below 0.

## Structure
- Shared package viterbi_pkg:
  - state enum (IDLE, FETCH, WAIT, EMIT, DONE).
  - SIZE_BM = 2.
  - Expected-pair constants 2'b00..2'b11.
  - The packing order of o_bm.
- One sub-module, bmu_hamming2: combinational; 2-bit pair in, four 2-bit metrics out; instantiated once.

## Test plan
- FIFO preloaded with 8'hE4; start with len=4, ready held high → o_bm = 94, 61, 49, 16 in consecutive cycles starting at cycle 3; o_last only on 16; o_done one cycle later.
- len=0 → o_done the cycle after start; o_fifo_rd_en never asserted; no o_bm_valid.
- len=6 with words E4, E4 → six transfers; second word pairs 2 and 3 discarded; exactly 2 FIFO reads.
- FIFO empty for 5 cycles after start, then one word written → FSM holds in FETCH with rd_en=0; first valid appears 2 cycles after empty deasserts.
- i_bm_ready low for 3 cycles during the first pair → o_bm holds 94 and pair_idx is unchanged; resumes at 61 when ready rises.
- Reset asserted mid-EMIT, then a new start → all outputs 0 immediately; the new frame starts from the next FIFO word; i_start asserted while busy has no effect.
